// File: rtl/apb_pwm_mc.sv
// apb_pwm_mc -- multi-channel APB PWM generator.
//
// A shared prescaler and period counter drive NCH duty comparators. The PERIOD
// and DUTY registers are shadows. Their values move into the active registers
// only at a period wrap, or continuously while the block is disabled, so an
// update never truncates or stretches a pulse that is already running.
//
// Ports
//   PCLK, PRESETn  clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR[19:2], PWDATA[31:0]
//                  APB slave inputs; decode uses PADDR[7:2]
//   PRDATA[31:0]   read data, combinational from PADDR
//   PREADY         always 1 (zero wait states)
//   PSLVERR        always 0
//   pwm_out[NCH]   registered PWM outputs
//   irq            registered level interrupt (WRAPF & IE)
//
// Register map (byte offsets)
//   0x00 CTRL    bit0 EN, bit1 ONESHOT
//   0x04 PRE     prescaler reload [PW-1:0]
//   0x08 PERIOD  period shadow [CW-1:0]
//   0x0C STATUS  bit0 WRAPF, write-1-to-clear
//   0x10 IE      bit0 interrupt enable
//   0x14 CNT     current counter value, read-only
//   0x20+4*i     DUTY[i] shadow [CW-1:0]
//   Reads of any other offset, including DUTY[i] for i >= NCH, return
//   32'hDEADBEEF.

module apb_pwm_mc #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16,
  parameter int unsigned PW  = 16
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  input  logic           PSEL,
  input  logic [19:2]    PADDR,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  output logic [NCH-1:0] pwm_out,
  output logic           irq
);

  // Word indices within the 256-byte window
  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_PRE    = 6'h01;
  localparam logic [5:0] A_PERIOD = 6'h02;
  localparam logic [5:0] A_STATUS = 6'h03;
  localparam logic [5:0] A_IE     = 6'h04;
  localparam logic [5:0] A_CNT    = 6'h05;

  // Register state
  logic          en;
  logic          oneshot;
  logic [PW-1:0] pre;
  logic [CW-1:0] per_sh;
  logic [CW-1:0] per_act;
  logic          wrapf;
  logic          ie;
  logic [CW-1:0] duty_sh  [NCH];
  logic [CW-1:0] duty_act [NCH];

  // Timebase
  logic [PW-1:0] pc;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          wrap;

  // Bus decode
  logic [5:0]    widx;
  logic          duty_win;
  logic [2:0]    duty_idx;
  logic          wr;
  logic          wr_ctrl;
  logic          wr_pre;
  logic          wr_period;
  logic          wr_status;
  logic          wr_ie;
  logic [NCH-1:0] wr_duty;
  logic [NCH-1:0] pwm_next;

  // Upper address bits and write-data bits beyond the field widths are
  // intentionally ignored.
  logic          unused_bits;
  assign unused_bits = ^{PADDR[19:8], PWDATA};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign widx     = PADDR[7:2];
  assign duty_win = (widx[5:3] == 3'b001);   // byte offsets 0x20..0x3C
  assign duty_idx = widx[2:0];

  assign wr        = PSEL & PWRITE & PENABLE;
  assign wr_ctrl   = wr && (widx == A_CTRL);
  assign wr_pre    = wr && (widx == A_PRE);
  assign wr_period = wr && (widx == A_PERIOD);
  assign wr_status = wr && (widx == A_STATUS);
  assign wr_ie     = wr && (widx == A_IE);

  always_comb begin
    wr_duty = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr_duty[i] = wr && duty_win && (duty_idx == 3'(i));
    end
  end

  // tick closes one prescaler interval; wrap closes one full period.
  assign tick = en && (pc == pre);
  assign wrap = tick && (cnt == per_act);

  // Control and status
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      pre     <= '0;
      per_sh  <= '0;
      wrapf   <= 1'b0;
      ie      <= 1'b0;
    end else begin
      // A CTRL write beats the one-shot auto-clear.
      if (wr_ctrl) begin
        en      <= PWDATA[0];
        oneshot <= PWDATA[1];
      end else if (wrap && oneshot) begin
        en <= 1'b0;
      end

      if (wr_pre)    pre    <= PWDATA[PW-1:0];
      if (wr_period) per_sh <= PWDATA[CW-1:0];
      if (wr_ie)     ie     <= PWDATA[0];

      // Set beats a coincident write-1-to-clear.
      if (wrap) begin
        wrapf <= 1'b1;
      end else if (wr_status && PWDATA[0]) begin
        wrapf <= 1'b0;
      end
    end
  end

  // Duty shadows
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_sh[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wr_duty[i]) duty_sh[i] <= PWDATA[CW-1:0];
      end
    end
  end

  // Active registers sample the shadows as they stood before this edge, so a
  // shadow write landing on the wrap edge is deferred to the following wrap.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      per_act <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_act[i] <= '0;
      end
    end else if (!en || wrap) begin
      per_act <= per_sh;
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_act[i] <= duty_sh[i];
      end
    end
  end

  // Prescaler and period counter. The counter returns to 0 through the
  // equality compare with per_act, never through overflow.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pc  <= '0;
      cnt <= '0;
    end else if (!en) begin
      pc  <= '0;
      cnt <= '0;
    end else begin
      if (tick) begin
        pc <= '0;
      end else begin
        pc <= pc + PW'(1);
      end

      if (wrap) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    pwm_next = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      pwm_next[i] = en && (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwm_out <= '0;
      irq     <= 1'b0;
    end else begin
      pwm_out <= pwm_next;
      irq     <= wrapf & ie;
    end
  end

  // Read mux; PERIOD and DUTY return the shadow values.
  always_comb begin
    PRDATA = 32'hDEADBEEF;
    case (widx)
      A_CTRL: begin
        PRDATA = '0;
        PRDATA[1:0] = {oneshot, en};
      end
      A_PRE: begin
        PRDATA = '0;
        PRDATA[PW-1:0] = pre;
      end
      A_PERIOD: begin
        PRDATA = '0;
        PRDATA[CW-1:0] = per_sh;
      end
      A_STATUS: begin
        PRDATA = '0;
        PRDATA[0] = wrapf;
      end
      A_IE: begin
        PRDATA = '0;
        PRDATA[0] = ie;
      end
      A_CNT: begin
        PRDATA = '0;
        PRDATA[CW-1:0] = cnt;
      end
      default: begin
        if (duty_win) begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (duty_idx == 3'(i)) begin
              PRDATA = '0;
              PRDATA[CW-1:0] = duty_sh[i];
            end
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_apb_pwm_mc.sv
// Testbench for apb_pwm_mc: directed scenarios plus randomized register
// traffic, checked every cycle against an elapsed-time reference model.
module tb_apb_pwm_mc;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned PW  = 16;
  localparam logic [31:0] CMASK = 32'((64'd1 << CW) - 1);
  localparam logic [31:0] PMASK = 32'((64'd1 << PW) - 1);

  logic           PCLK = 1'b0;
  logic           PRESETn = 1'b0;
  logic           PSEL = 1'b0;
  logic [19:2]    PADDR = '0;
  logic           PENABLE = 1'b0;
  logic           PWRITE = 1'b0;
  logic [31:0]    PWDATA = '0;
  logic [31:0]    PRDATA;
  logic           PREADY;
  logic           PSLVERR;
  logic [NCH-1:0] pwm_out;
  logic           irq;

  apb_pwm_mc #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PADDR   (PADDR),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time inside a period is a single elapsed-cycle count
  // (phase); the counter value is phase / (PRE+1) and a period lasts
  // (PERIOD+1)*(PRE+1) cycles.
  bit              m_en = 0, m_os = 0, m_wrapf = 0, m_ie = 0, m_irq = 0;
  int unsigned     m_pre = 0, m_per_sh = 0, m_per_act = 0;
  int unsigned     m_duty_sh [NCH] = '{default: 0};
  int unsigned     m_duty_act[NCH] = '{default: 0};
  longint unsigned m_phase = 0;
  logic [NCH-1:0]  m_pwm = '0;

  bit              mw, mwrap;
  int unsigned     mo, mi;
  longint unsigned mlen, mcnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_en = 0; m_os = 0; m_wrapf = 0; m_ie = 0; m_irq = 0;
      m_pre = 0; m_per_sh = 0; m_per_act = 0; m_phase = 0; m_pwm = '0;
      for (int i = 0; i < NCH; i++) begin
        m_duty_sh[i] = 0;
        m_duty_act[i] = 0;
      end
    end else begin
      mw    = PSEL && PWRITE && PENABLE;
      mo    = {24'b0, PADDR[7:2], 2'b00};
      mlen  = (longint'(m_pre) + 1) * (longint'(m_per_act) + 1);
      mwrap = m_en && (m_phase == mlen - 1);
      mcnt  = m_phase / (longint'(m_pre) + 1);
      for (int i = 0; i < NCH; i++) m_pwm[i] = m_en && (mcnt < longint'(m_duty_act[i]));
      m_irq = m_wrapf && m_ie;
      if (!m_en || mwrap) begin
        m_per_act = m_per_sh;
        for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_sh[i];
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
      if (mwrap) m_wrapf = 1;
      else if (mw && mo == 32'h0C && PWDATA[0]) m_wrapf = 0;
      if (mw && mo == 32'h00) begin
        m_en = PWDATA[0];
        m_os = PWDATA[1];
      end else if (mwrap && m_os) begin
        m_en = 0;
      end
      if (mw) begin
        if (mo == 32'h04) m_pre = PWDATA & PMASK;
        if (mo == 32'h08) m_per_sh = PWDATA & CMASK;
        if (mo == 32'h10) m_ie = PWDATA[0];
        if (mo >= 32'h20 && mo <= 32'h3C) begin
          mi = (mo - 32'h20) / 4;
          if (mi < NCH) m_duty_sh[mi] = PWDATA & CMASK;
        end
      end
    end
  end

  function automatic logic [31:0] model_read(input int unsigned a);
    int unsigned o = a & 32'hFC;
    if (o == 32'h00) return {30'b0, m_os, m_en};
    if (o == 32'h04) return m_pre;
    if (o == 32'h08) return m_per_sh;
    if (o == 32'h0C) return {31'b0, m_wrapf};
    if (o == 32'h10) return {31'b0, m_ie};
    if (o == 32'h14) return 32'(m_phase / (longint'(m_pre) + 1));
    if (o >= 32'h20 && o <= 32'h3C && (o - 32'h20) / 4 < NCH) return m_duty_sh[(o - 32'h20) / 4];
    return 32'hDEADBEEF;
  endfunction

  // Every-cycle output comparison, sampled on the falling edge
  bit auto_on = 0;
  always @(negedge PCLK) begin
    if (auto_on && PRESETn) begin
      check("pwm_out", pwm_out, m_pwm);
      check("irq", irq, m_irq);
    end
  end

  // Bus tasks: entered and left just after a falling edge
  task automatic apb_wr(input int unsigned a, input logic [31:0] d);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PWDATA = d;
    PADDR = {12'($urandom), 6'(a >> 2)};
    @(negedge PCLK);
    PENABLE = 1;
    #1 check("pready_wr", PREADY, 1'b1);
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_rd(input int unsigned a, input string tag, output logic [31:0] v);
    PSEL = 1; PWRITE = 0; PENABLE = 0;
    PADDR = {12'($urandom), 6'(a >> 2)};
    @(negedge PCLK);
    PENABLE = 1;
    #1;
    v = PRDATA;
    check(tag, PRDATA, model_read(a));
    check("pready_rd", PREADY, 1'b1);
    check("pslverr", PSLVERR, 1'b0);
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic wait_phase(input longint unsigned target);
    int k = 0;
    while (!(m_en && m_phase == target) && k < 2000) begin
      @(negedge PCLK);
      k++;
    end
    check("wait_phase_timeout", k < 2000, 1'b1);
  endtask

  task automatic count_high(input int ch, input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge PCLK);
      c += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] v;
  int c;
  int unsigned r;
  int unsigned reg_list [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h24};

  initial begin
    repeat (3) @(negedge PCLK);
    check("rst_pwm", pwm_out, '0);
    check("rst_irq", irq, 1'b0);
    PRESETn = 1;
    auto_on = 1;
    @(negedge PCLK);
    foreach (reg_list[k]) begin
      apb_rd(reg_list[k], "rst_rd", v);
      check("rst_reg_zero", v, 32'h0);
    end

    // Basic PWM: period 10, ch0 high 3 cycles
    apb_wr(32'h04, 0);
    apb_wr(32'h08, 9);
    apb_wr(32'h20, 3);
    apb_wr(32'h00, 1);
    idle(25);
    count_high(0, 10, c);
    check("basic_high_ch0", c, 3);
    apb_rd(32'h0C, "basic_status", v);
    check("basic_wrapf", v, 1);

    // Prescaler 1, PERIOD 4 and duty corners
    apb_wr(32'h00, 0);
    apb_wr(32'h04, 1);
    apb_wr(32'h08, 4);
    apb_wr(32'h24, 0);
    apb_wr(32'h28, 5);
    apb_wr(32'h2C, 2);
    apb_wr(32'h00, 1);
    idle(25);
    count_high(1, 10, c);
    check("pre_ch1_zero", c, 0);
    count_high(2, 10, c);
    check("pre_ch2_full", c, 10);
    count_high(3, 10, c);
    check("pre_ch3_high", c, 4);
    count_high(0, 10, c);
    check("pre_ch0_high", c, 6);

    // Shadow timing: DUTY0 3 -> 7 mid-period
    apb_wr(32'h00, 0);
    apb_wr(32'h04, 0);
    apb_wr(32'h08, 9);
    apb_wr(32'h20, 3);
    apb_wr(32'h00, 1);
    wait_phase(3);
    apb_wr(32'h20, 7);
    apb_rd(32'h20, "shadow_rd", v);
    check("shadow_readback", v, 7);
    wait_phase(0);
    idle(2);
    count_high(0, 10, c);
    check("shadow_new_high", c, 7);

    // DUTY0 write landing on the wrap edge
    wait_phase(8);
    apb_wr(32'h20, 2);
    count_high(0, 10, c);
    check("wrapwr_old_duty", c, 7);
    count_high(0, 10, c);
    check("wrapwr_new_duty", c, 2);

    // W1C STATUS on the wrap edge: set wins
    wait_phase(8);
    apb_wr(32'h0C, 1);
    apb_rd(32'h0C, "w1c_wrap_rd", v);
    check("w1c_on_wrap", v, 1);

    // ONESHOT with interrupt
    apb_wr(32'h00, 0);
    apb_wr(32'h0C, 1);
    apb_wr(32'h10, 1);
    apb_wr(32'h04, 0);
    apb_wr(32'h08, 3);
    apb_wr(32'h20, 2);
    apb_wr(32'h00, 3);
    count_high(0, 12, c);
    check("oneshot_high", c, 2);
    apb_rd(32'h00, "oneshot_ctrl_rd", v);
    check("oneshot_en_clr", v, 2);
    check("oneshot_irq", irq, 1'b1);
    apb_wr(32'h0C, 1);
    idle(1);
    check("irq_fall", irq, 1'b0);

    // Unmapped accesses
    apb_wr(32'h3C, 32'h5);
    apb_wr(32'h18, 32'h1234);
    apb_rd(32'h3C, "unmapped_duty7", v);
    check("deadbeef_3c", v, 32'hDEADBEEF);
    apb_rd(32'h18, "unmapped_18", v);
    apb_rd(32'h1C, "unmapped_1c", v);
    apb_rd(32'h40, "unmapped_40", v);

    // Randomized traffic
    repeat (300) begin
      r = $urandom_range(0, 8);
      case (r)
        0: apb_wr(32'h20 + 4 * $urandom_range(0, NCH - 1), $urandom_range(0, m_per_sh + 2));
        1: apb_wr(32'h08, $urandom_range(0, 9));
        2: apb_rd(4 * $urandom_range(0, 20), "rand_rd", v);
        3: apb_wr(32'h0C, $urandom_range(0, 1));
        4: apb_wr(32'h10, $urandom_range(0, 1));
        5: if (!m_en) apb_wr(32'h04, $urandom_range(0, 3)); else idle(1);
        6: begin
          r = $urandom_range(0, 3);
          apb_wr(32'h00, (r == 0) ? 0 : (r == 1) ? 3 : 1);
        end
        7: idle($urandom_range(1, 12));
        default: apb_wr(($urandom_range(0, 1) == 0) ? 32'h18 : 32'h3C, $urandom);
      endcase
    end

    // Reset mid-period
    apb_wr(32'h04, 0);
    apb_wr(32'h08, 9);
    apb_wr(32'h20, 5);
    apb_wr(32'h10, 1);
    apb_wr(32'h00, 1);
    idle(14);
    PRESETn = 0;
    #1;
    check("rst_mid_pwm", pwm_out, '0);
    check("rst_mid_irq", irq, 1'b0);
    foreach (reg_list[k]) begin
      PADDR = {12'($urandom), 6'(reg_list[k] >> 2)};
      #1 check("rst_mid_reg", PRDATA, 32'h0);
    end
    @(negedge PCLK);
    PRESETn = 1;
    @(negedge PCLK);
    foreach (reg_list[k]) apb_rd(reg_list[k], "post_rst_rd", v);
    idle(5);

    auto_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
